// File: rtl/learn_guide.sv
// Piano learning guide: walks a song ROM, lights the expected key and scores presses.
// Optional LEARN_TIMEOUT_EN: a note left unplayed for TIMEOUT_TICKS ticks counts as an error and advances.
module learn_guide #(
    parameter int NKEYS         = 7,
    parameter int DEPTH         = 64,
    parameter int TICK_DIV      = 100_000_000,
    parameter int TIMEOUT_TICKS = 3,
    parameter int SCORE_W       = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         start,
    input  logic [$clog2(DEPTH):0]       song_len,
    input  logic [NKEYS-1:0]             key,
    output logic [$clog2(DEPTH)-1:0]     rom_addr,
    input  logic [$clog2(NKEYS+1)-1:0]   rom_note,
    output logic [NKEYS-1:0]             led,
    output logic [$clog2(NKEYS+1)-1:0]   note_out,
    output logic                         right,
    output logic                         wrong,
    output logic                         busy,
    output logic                         finished,
    output logic [SCORE_W-1:0]           score,
    output logic [7:0]                   errors
);

    // state   | meaning
    // IDLE    | learning mode off or not started
    // FETCH   | rom_addr presents idx
    // WAIT    | rom_note valid, latched into exp_note
    // PROMPT  | led shows expected key, presses judged
    // RELEASE | correct key held, buzzer sounds until release
    // DONE    | song complete, results frozen
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_PROMPT  = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam int AW = $clog2(DEPTH);
    localparam int KW = $clog2(NKEYS + 1);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam logic [TW-1:0] TICK_LOAD = TW'(TICK_DIV - 1);

    logic [2:0]         state;
    logic [AW-1:0]      idx;
    logic [KW-1:0]      exp_note;
    logic [NKEYS-1:0]   key_s1;
    logic [NKEYS-1:0]   key_s2;
    logic [NKEYS-1:0]   key_d;
    logic [TW-1:0]      tick_cnt;
    logic [NKEYS-1:0]   exp_oh;
    logic               press;
    logic               tick;
    logic               timeout;
    logic               last;
    logic               advance;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_add;
    logic [7:0]         err_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= '0;
            key_s2 <= '0;
            key_d  <= '0;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
            key_d  <= key_s2;
        end
    end

    assign press = (key_s2 != '0) && (key_d == '0);

    always_comb begin
        exp_oh = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (exp_note == KW'(i + 1)) exp_oh[i] = 1'b1;
        end
    end

    // Tick prescaler reloads on PROMPT entry so a rest lasts exactly TICK_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (state == S_WAIT) begin
            tick_cnt <= TICK_LOAD;
        end else if (state == S_PROMPT) begin
            tick_cnt <= (tick_cnt == '0) ? TICK_LOAD : tick_cnt - TW'(1);
        end else begin
            tick_cnt <= '0;
        end
    end

    assign tick = (state == S_PROMPT) && (tick_cnt == '0);

`ifdef LEARN_TIMEOUT_EN
    localparam int MW = $clog2(TIMEOUT_TICKS + 1);
    logic [MW-1:0] tmo_left;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_left <= '0;
        end else if (state == S_WAIT) begin
            tmo_left <= MW'(TIMEOUT_TICKS - 1);
        end else if (tick && tmo_left != '0) begin
            tmo_left <= tmo_left - MW'(1);
        end
    end

    assign timeout = tick && (tmo_left == '0);
`else
    assign timeout = 1'b0;
`endif

    assign last      = ({1'b0, idx} + (AW + 1)'(1)) == song_len;
    assign score_sum = {1'b0, score} + (SCORE_W + 1)'(10);
    assign score_add = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    assign err_inc   = (errors == 8'hFF) ? errors : errors + 8'd1;

    // A press on a real note always wins over a simultaneous timeout.
    always_comb begin
        advance = 1'b0;
        case (state)
            S_PROMPT:  advance = (exp_note == '0) ? tick : (!press && timeout);
            S_RELEASE: advance = (key_s2 == '0);
            default:   advance = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            exp_note <= '0;
            score    <= '0;
            errors   <= '0;
            right    <= 1'b0;
            wrong    <= 1'b0;
            finished <= 1'b0;
        end else begin
            right <= 1'b0;
            wrong <= 1'b0;
            if (!en) begin
                state <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            score  <= '0;
                            errors <= '0;
                            idx    <= '0;
                            if (song_len == '0) begin
                                state    <= S_DONE;
                                finished <= 1'b1;
                            end else begin
                                state    <= S_FETCH;
                                finished <= 1'b0;
                            end
                        end
                    end
                    S_FETCH: state <= S_WAIT;
                    S_WAIT: begin
                        exp_note <= rom_note;
                        state    <= S_PROMPT;
                    end
                    S_PROMPT: begin
                        if (exp_note != '0) begin
                            if (press) begin
                                if (key_s2 == exp_oh) begin
                                    right <= 1'b1;
                                    score <= score_add;
                                    state <= S_RELEASE;
                                end else begin
                                    wrong  <= 1'b1;
                                    errors <= err_inc;
                                end
                            end else if (timeout) begin
                                wrong  <= 1'b1;
                                errors <= err_inc;
                            end
                        end
                    end
                    S_RELEASE: ;
                    default: state <= S_IDLE;
                endcase
                if (advance) begin
                    if (last) begin
                        state    <= S_DONE;
                        finished <= 1'b1;
                    end else begin
                        idx   <= idx + AW'(1);
                        state <= S_FETCH;
                    end
                end
            end
        end
    end

    assign rom_addr = idx;
    assign led      = (state == S_PROMPT) ? exp_oh : '0;
    assign note_out = (state == S_RELEASE && (key_s2 & exp_oh) != '0) ? exp_note : '0;
    assign busy     = (state == S_FETCH) || (state == S_WAIT) ||
                      (state == S_PROMPT) || (state == S_RELEASE);

endmodule

// File: tb/tb_learn_guide.sv
// Bench for learn_guide: directed key-classification table, song scenarios and random songs.
module tb_learn_guide;
    localparam int NKEYS = 7;
    localparam int DEPTH = 64;
    localparam int AW = 6;
    localparam int KW = 3;
    localparam int SCORE_W = 16;

    logic clk = 1'b0;
    logic rst_n, en, start;
    logic [AW:0] song_len;
    logic [NKEYS-1:0] key;
    logic [AW-1:0] rom_addr;
    logic [KW-1:0] rom_note;
    logic [NKEYS-1:0] led;
    logic [KW-1:0] note_out;
    logic right, wrong, busy, finished;
    logic [SCORE_W-1:0] score;
    logic [7:0] errors;

    logic [KW-1:0] rom [DEPTH];
    int n_vec = 0;
    int n_bad = 0;
    int n_right = 0;
    int n_wrong = 0;

    learn_guide #(.NKEYS(NKEYS), .DEPTH(DEPTH), .TICK_DIV(4), .TIMEOUT_TICKS(3), .SCORE_W(SCORE_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .song_len(song_len), .key(key),
        .rom_addr(rom_addr), .rom_note(rom_note), .led(led), .note_out(note_out),
        .right(right), .wrong(wrong), .busy(busy), .finished(finished),
        .score(score), .errors(errors)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_note <= rom[rom_addr];

    always @(negedge clk) begin
        if (right === 1'b1) n_right++;
        if (wrong === 1'b1) n_wrong++;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         note;
        logic [6:0] keys;
        logic [6:0] exp_led;
        int         exp_right;
        int         exp_wrong;
    } vec_t;

    function automatic logic [6:0] oh(input int n);
        logic [6:0] one;
        one = 7'd1;
        return (n == 0) ? 7'd0 : (one << (n - 1));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic abort;
        key = '0;
        start = 1'b0;
        en = 1'b0;
        step(2);
        en = 1'b1;
        step(1);
    endtask

    task automatic wait_led(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (led != '0) begin ok = 1; break; end
            @(negedge clk);
        end
        check({name, "_led_wait"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_addr(input int a, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            if (int'(rom_addr) == a) begin ok = 1; break; end
            @(negedge clk);
        end
        check({name, "_addr_wait"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_fin(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (finished) begin ok = 1; break; end
            @(negedge clk);
        end
        check({name, "_fin_wait"}, 32'(ok), 32'd1);
    endtask

    task automatic press_key(input logic [6:0] pat, input int hold, input int gap);
        key = pat;
        step(hold);
        key = '0;
        step(gap);
    endtask

    // Plays one note: nw wrong presses then the correct key.
    task automatic play_note(input int note, input int nw);
        logic [6:0] pat;
        wait_led("play");
        check("play_led", 32'(led), 32'(oh(note)));
        for (int w = 0; w < nw; w++) begin
            do pat = 7'($urandom_range(1, 127)); while (pat == oh(note));
            press_key(pat, 4, 4);
        end
        key = oh(note);
        step(4);
        check("play_note_out", 32'(note_out), 32'(note));
        key = '0;
        step(1);
    endtask

    vec_t tbl[8];
    int r0, w0, cnt, bad, nw, len, exp_score, exp_err;

    initial begin
        tbl[0] = '{5, 7'b0010000, 7'b0010000, 1, 0};
        tbl[1] = '{5, 7'b0000010, 7'b0010000, 0, 1};
        tbl[2] = '{5, 7'b0010001, 7'b0010000, 0, 1};
        tbl[3] = '{1, 7'b0000001, 7'b0000001, 1, 0};
        tbl[4] = '{7, 7'b1000000, 7'b1000000, 1, 0};
        tbl[5] = '{7, 7'b0111111, 7'b1000000, 0, 1};
        tbl[6] = '{3, 7'b0000100, 7'b0000100, 1, 0};
        tbl[7] = '{3, 7'b1111111, 7'b0000100, 0, 1};

        for (int i = 0; i < DEPTH; i++) rom[i] = '0;
        rst_n = 1'b0; en = 1'b0; start = 1'b0; key = '0; song_len = '0;
        step(2);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_led", 32'(led), 0);
        check("rst_note_out", 32'(note_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_finished", 32'(finished), 0);
        check("rst_score", 32'(score), 0);
        check("rst_errors", 32'(errors), 0);
        check("rst_verdict", 32'({right, wrong}), 0);
        rst_n = 1'b1;
        en = 1'b1;
        step(2);

        // Press classification table, single-note songs
        for (int v = 0; v < 8; v++) begin
            rom[0] = KW'(tbl[v].note);
            song_len = 7'd1;
            pulse_start;
            wait_led("tbl");
            check("tbl_led", 32'(led), 32'(tbl[v].exp_led));
            r0 = n_right; w0 = n_wrong;
            key = tbl[v].keys;
            step(5);
            key = '0;
            step(4);
            check("tbl_right", 32'(n_right - r0), 32'(tbl[v].exp_right));
            check("tbl_wrong", 32'(n_wrong - w0), 32'(tbl[v].exp_wrong));
            check("tbl_finished", 32'(finished), 32'(tbl[v].exp_right));
            abort;
        end

        // Correct play through {5,0,3,1}
        rom[0] = 3'd5; rom[1] = 3'd0; rom[2] = 3'd3; rom[3] = 3'd1;
        song_len = 7'd4;
        r0 = n_right; w0 = n_wrong;
        pulse_start;
        check("play_busy", 32'(busy), 1);
        check("play_addr0", 32'(rom_addr), 0);
        play_note(5, 0);
        wait_addr(1, "rest");
        cnt = 0; bad = 0;
        key = 7'b0001000;
        for (int i = 0; i < 20; i++) begin
            if (rom_addr != 6'd1) break;
            if (led != '0) bad++;
            cnt++;
            if (cnt == 3) key = '0;
            step(1);
        end
        check("rest_cycles", 32'(cnt), 6);
        check("rest_led", 32'(bad), 0);
        wait_addr(2, "play");
        play_note(3, 0);
        wait_addr(3, "play");
        play_note(1, 0);
        wait_fin("play");
        step(2);
        check("play_finished", 32'(finished), 1);
        check("play_score", 32'(score), 30);
        check("play_errors", 32'(errors), 0);
        check("play_rights", 32'(n_right - r0), 3);
        check("play_wrongs", 32'(n_wrong - w0), 0);
        check("done_led", 32'(led), 0);
        check("done_busy", 32'(busy), 0);

        // Wrong key then right key
        r0 = n_right; w0 = n_wrong;
        pulse_start;
        check("restart_score", 32'(score), 0);
        check("restart_finished", 32'(finished), 0);
        wait_led("wk");
        press_key(7'b0000010, 4, 4);
        check("wk_led_held", 32'(led), 32'h10);
        check("wk_errors", 32'(errors), 1);
        key = 7'b0010000;
        step(4);
        check("wk_score", 32'(score), 10);
        check("wk_release_led", 32'(led), 0);
        key = '0;
        step(3);
        check("wk_rights", 32'(n_right - r0), 1);
        check("wk_wrongs", 32'(n_wrong - w0), 1);
        abort;

`ifdef LEARN_TIMEOUT_EN
        w0 = n_wrong;
        pulse_start;
        wait_led("tmo");
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            cnt++;
            if (wrong) break;
        end
        check("tmo_latency", 32'(cnt), 12);
        wait_fin("tmo");
        step(2);
        check("tmo_errors", 32'(errors), 3);
        check("tmo_score", 32'(score), 0);
        check("tmo_finished", 32'(finished), 1);
        check("tmo_wrongs", 32'(n_wrong - w0), 3);
        abort;
`else
        w0 = n_wrong;
        pulse_start;
        wait_led("hold");
        bad = 0;
        repeat (1000) begin
            if (led != 7'b0010000 || !busy) bad++;
            step(1);
        end
        check("hold_prompt", 32'(bad), 0);
        check("hold_wrongs", 32'(n_wrong - w0), 0);
        abort;

        // Error counter saturation
        rom[0] = 3'd2;
        song_len = 7'd1;
        pulse_start;
        wait_led("sat");
        repeat (260) press_key(7'b0000001, 4, 4);
        check("sat_errors", 32'(errors), 255);
        press_key(7'b0000010, 4, 4);
        check("sat_score", 32'(score), 10);
        check("sat_errors_after", 32'(errors), 255);
        abort;
        rom[0] = 3'd5;
        song_len = 7'd4;
`endif

        // Abort during RELEASE of entry 0
        pulse_start;
        wait_led("abort");
        key = 7'b0010000;
        step(4);
        en = 1'b0;
        step(1);
        check("abort_busy", 32'(busy), 0);
        check("abort_led", 32'(led), 0);
        check("abort_note_out", 32'(note_out), 0);
        check("abort_score", 32'(score), 10);
        step(3);
        check("abort_score_held", 32'(score), 10);
        key = '0;
        en = 1'b1;
        step(3);
        pulse_start;
        check("abort_restart_score", 32'(score), 0);
        check("abort_restart_addr", 32'(rom_addr), 0);
        check("abort_restart_busy", 32'(busy), 1);
        abort;

        // Reset mid-PROMPT
        pulse_start;
        play_note(5, 0);
        wait_addr(2, "rst");
        wait_led("rst");
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_outputs", 32'({rom_addr, led, note_out, right, wrong, busy, finished}), 0);
        check("mid_rst_score", 32'(score), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(5);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_addr", 32'(rom_addr), 0);

        // Empty song
        song_len = '0;
        pulse_start;
        check("empty_finished", 32'(finished), 1);
        check("empty_busy", 32'(busy), 0);

        // Start ignored while busy
        song_len = 7'd4;
        pulse_start;
        play_note(5, 0);
        wait_addr(1, "busy_start");
        pulse_start;
        check("busy_start_addr", 32'(rom_addr), 1);
        check("busy_start_busy", 32'(busy), 1);
        abort;

        // Random songs against a song-level model
        for (int s = 0; s < 6; s++) begin
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) rom[i] = KW'($urandom_range(0, 7));
            song_len = 7'(len);
            exp_score = 0; exp_err = 0;
            r0 = n_right; w0 = n_wrong;
            pulse_start;
            for (int i = 0; i < len; i++) begin
                wait_addr(i, "rnd");
                if (rom[i] != '0) begin
`ifdef LEARN_TIMEOUT_EN
                    nw = 0;
`else
                    nw = $urandom_range(0, 2);
`endif
                    play_note(int'(rom[i]), nw);
                    exp_score += 10;
                    exp_err = (exp_err + nw > 255) ? 255 : exp_err + nw;
                end
            end
            wait_fin("rnd");
            step(2);
            check("rnd_score", 32'(score), 32'(exp_score));
            check("rnd_errors", 32'(errors), 32'(exp_err));
            check("rnd_rights", 32'(n_right - r0), 32'(exp_score / 10));
            check("rnd_wrongs", 32'(n_wrong - w0), 32'(exp_err));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
